// File: rtl/digit_entry.sv
// digit_entry: four-digit code entry with a blinking cursor.
// Button pulses edit four digit registers, the code is submitted
// with btn_enter and compared against a secret. Digit value 10 ('A')
// acts as a wildcard when WILDCARD_EN is set. The digit outputs feed
// a seven-segment driver directly, where 15 means blank.
module digit_entry #(
    parameter int BLINK_BITS  = 24,
    parameter bit WILDCARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_next,
    input  logic        btn_enter,
    input  logic [15:0] secret,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [15:0] entered_code,
    output logic        code_valid,
    output logic        match,
    output logic        editing
);

    // Largest legal digit value; values above it wrap back to 0.
    localparam logic [3:0] MAX_DIGIT = WILDCARD_EN ? 4'd10 : 4'd9;
    localparam logic [3:0] WILD_CODE = 4'd10;
    localparam logic [3:0] BLANK     = 4'd15;
    localparam logic [BLINK_BITS-1:0] BLINK_ZERO = {BLINK_BITS{1'b0}};
    localparam logic [BLINK_BITS-1:0] BLINK_ONE  = {{(BLINK_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EDIT   = 2'd0,
        ST_SUBMIT = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Next value for an up press; any out-of-range value recovers to 0.
    function automatic logic [3:0] digit_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v >= MAX_DIGIT) begin
            r = 4'd0;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Next value for a down press; out-of-range values recover to max.
    function automatic logic [3:0] digit_dec(input logic [3:0] v);
        logic [3:0] r;
        if ((v == 4'd0) || (v > MAX_DIGIT)) begin
            r = MAX_DIGIT;
        end else begin
            r = v - 4'd1;
        end
        return r;
    endfunction

    // One digit position matches if equal, or if it is a wildcard.
    function automatic logic digit_hit(input logic [3:0] d, input logic [3:0] s);
        return (d == s) || (WILDCARD_EN && (d == WILD_CODE));
    endfunction

    // Whole-code comparison: every position must hit.
    function automatic logic code_match(input logic [15:0] code, input logic [15:0] sec);
        logic hit;
        hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hit = hit & digit_hit(code[4*i +: 4], sec[4*i +: 4]);
        end
        return hit;
    endfunction

    // Display code for one digit; never lets 11..14 reach the driver.
    function automatic logic [3:0] show_digit(input logic [3:0] v, input logic blank);
        logic [3:0] r;
        if (blank) begin
            r = BLANK;
        end else if (v > MAX_DIGIT) begin
            r = BLANK;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_r;
    logic [3:0]            digit_r [0:3];
    logic [1:0]            cursor_r;
    logic [BLINK_BITS-1:0] blink_r;
    logic [15:0]           entered_code_r;
    logic                  code_valid_r;
    logic                  match_r;
    logic                  editing_r;

    logic                  any_btn_s;
    logic                  blink_on_s;
    logic [15:0]           edit_code_s;
    logic [3:0]            digit0_s;
    logic [3:0]            digit1_s;
    logic [3:0]            digit2_s;
    logic [3:0]            digit3_s;

    assign any_btn_s   = btn_up | btn_down | btn_next | btn_enter;
    assign edit_code_s = {digit_r[3], digit_r[2], digit_r[1], digit_r[0]};

    // Main controller: state, digit registers, cursor and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_EDIT;
            digit_r[0]     <= 4'd0;
            digit_r[1]     <= 4'd0;
            digit_r[2]     <= 4'd0;
            digit_r[3]     <= 4'd0;
            cursor_r       <= 2'd3;
            entered_code_r <= 16'd0;
            code_valid_r   <= 1'b0;
            match_r        <= 1'b0;
            editing_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_EDIT: begin
                    code_valid_r <= 1'b0;
                    editing_r    <= 1'b1;
                    // Priority: enter > next > up > down.
                    if (btn_enter) begin
                        entered_code_r <= edit_code_s;
                        code_valid_r   <= 1'b1;
                        editing_r      <= 1'b0;
                        state_r        <= ST_SUBMIT;
                    end else if (btn_next) begin
                        // 3 -> 2 -> 1 -> 0 -> 3 falls out of 2-bit wrap.
                        cursor_r <= cursor_r - 2'd1;
                    end else if (btn_up) begin
                        digit_r[cursor_r] <= digit_inc(digit_r[cursor_r]);
                    end else if (btn_down) begin
                        digit_r[cursor_r] <= digit_dec(digit_r[cursor_r]);
                    end else begin
                        state_r <= ST_EDIT;
                    end
                end
                ST_SUBMIT: begin
                    // Secret is only looked at here; buttons are ignored.
                    code_valid_r <= 1'b0;
                    editing_r    <= 1'b0;
                    match_r      <= code_match(entered_code_r, secret);
                    state_r      <= ST_RESULT;
                end
                ST_RESULT: begin
                    code_valid_r <= 1'b0;
                    // Any press acknowledges the result and starts over
                    // without applying an edit.
                    if (any_btn_s) begin
                        digit_r[0] <= 4'd0;
                        digit_r[1] <= 4'd0;
                        digit_r[2] <= 4'd0;
                        digit_r[3] <= 4'd0;
                        cursor_r   <= 2'd3;
                        match_r    <= 1'b0;
                        editing_r  <= 1'b1;
                        state_r    <= ST_EDIT;
                    end else begin
                        editing_r <= 1'b0;
                        state_r   <= ST_RESULT;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a clean edit session.
                    digit_r[0]   <= 4'd0;
                    digit_r[1]   <= 4'd0;
                    digit_r[2]   <= 4'd0;
                    digit_r[3]   <= 4'd0;
                    cursor_r     <= 2'd3;
                    code_valid_r <= 1'b0;
                    match_r      <= 1'b0;
                    editing_r    <= 1'b1;
                    state_r      <= ST_EDIT;
                end
            endcase
        end
    end

    // Blink counter: free-runs while editing, restarts on every press so
    // the digit just edited is visible straight away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_r <= BLINK_ZERO;
        end else if (state_r != ST_EDIT) begin
            blink_r <= BLINK_ZERO;
        end else if (any_btn_s) begin
            blink_r <= BLINK_ZERO;
        end else begin
            blink_r <= blink_r + BLINK_ONE;
        end
    end

    // Display decode: blank the cursor digit during the off blink phase.
    always_comb begin
        blink_on_s = 1'b0;
        digit0_s   = BLANK;
        digit1_s   = BLANK;
        digit2_s   = BLANK;
        digit3_s   = BLANK;
        if (state_r == ST_EDIT) begin
            blink_on_s = blink_r[BLINK_BITS-1];
        end else begin
            blink_on_s = 1'b0;
        end
        digit0_s = show_digit(digit_r[0], blink_on_s && (cursor_r == 2'd0));
        digit1_s = show_digit(digit_r[1], blink_on_s && (cursor_r == 2'd1));
        digit2_s = show_digit(digit_r[2], blink_on_s && (cursor_r == 2'd2));
        digit3_s = show_digit(digit_r[3], blink_on_s && (cursor_r == 2'd3));
    end

    assign digit0       = digit0_s;
    assign digit1       = digit1_s;
    assign digit2       = digit2_s;
    assign digit3       = digit3_s;
    assign entered_code = entered_code_r;
    assign code_valid   = code_valid_r;
    assign match        = match_r;
    assign editing      = editing_r;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: two instances (wildcard on and
// off) share all inputs and are compared each cycle against a
// behavioural model of the entry rules.
module tb_digit_entry;

    localparam int BB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_down, btn_next, btn_enter;
    logic [15:0] secret;

    logic [3:0]  w_d0, w_d1, w_d2, w_d3;
    logic [15:0] w_code;
    logic        w_cv, w_m, w_ed;
    logic [3:0]  n_d0, n_d1, n_d2, n_d3;
    logic [15:0] n_code;
    logic        n_cv, n_m, n_ed;

    int checks   = 0;
    int failures = 0;

    digit_entry #(.BLINK_BITS(BB), .WILDCARD_EN(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next), .btn_enter(btn_enter),
        .secret(secret),
        .digit0(w_d0), .digit1(w_d1), .digit2(w_d2), .digit3(w_d3),
        .entered_code(w_code), .code_valid(w_cv), .match(w_m), .editing(w_ed)
    );

    digit_entry #(.BLINK_BITS(BB), .WILDCARD_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next), .btn_enter(btn_enter),
        .secret(secret),
        .digit0(n_d0), .digit1(n_d1), .digit2(n_d2), .digit3(n_d3),
        .entered_code(n_code), .code_valid(n_cv), .match(n_m), .editing(n_ed)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = EDIT, 1 = SUBMIT, 2 = RESULT
    int          m_phase;
    int          m_cursor;
    int          m_cnt;
    int          m_d [2][4];
    int          m_match [2];
    logic [15:0] m_code [2];

    function automatic int maxd(int k);
        return (k == 0) ? 10 : 9;
    endfunction

    function automatic int sec_digit(int i);
        return int'((secret >> (4 * i)) & 16'h000F);
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_cursor = 3;
        m_cnt    = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) m_d[k][i] = 0;
            m_match[k] = 0;
            m_code[k]  = 16'd0;
        end
    endtask

    task automatic model_step();
        bit any;
        any = btn_up | btn_down | btn_next | btn_enter;
        if (m_phase == 0) begin
            if (any) m_cnt = 0;
            else     m_cnt = (m_cnt + 1) % (1 << BB);
            if (btn_enter) begin
                for (int k = 0; k < 2; k++)
                    m_code[k] = 16'(m_d[k][3] * 4096 + m_d[k][2] * 256 + m_d[k][1] * 16 + m_d[k][0]);
                m_phase = 1;
            end else if (btn_next) begin
                m_cursor = (m_cursor + 3) % 4;
            end else if (btn_up) begin
                for (int k = 0; k < 2; k++)
                    m_d[k][m_cursor] = (m_d[k][m_cursor] + 1) % (maxd(k) + 1);
            end else if (btn_down) begin
                for (int k = 0; k < 2; k++)
                    m_d[k][m_cursor] = (m_d[k][m_cursor] + maxd(k)) % (maxd(k) + 1);
            end
        end else if (m_phase == 1) begin
            for (int k = 0; k < 2; k++) begin
                m_match[k] = 1;
                for (int i = 0; i < 4; i++) begin
                    if (!(m_d[k][i] == sec_digit(i) || (k == 0 && m_d[k][i] == 10)))
                        m_match[k] = 0;
                end
            end
            m_phase = 2;
            m_cnt   = 0;
        end else begin
            m_cnt = 0;
            if (any) begin
                for (int k = 0; k < 2; k++) begin
                    for (int i = 0; i < 4; i++) m_d[k][i] = 0;
                    m_match[k] = 0;
                end
                m_cursor = 3;
                m_phase  = 0;
            end
        end
    endtask

    function automatic logic [15:0] exp_disp(int k);
        int v [4];
        for (int i = 0; i < 4; i++) begin
            if (m_phase == 0 && i == m_cursor && m_cnt >= (1 << (BB - 1))) v[i] = 15;
            else v[i] = m_d[k][i];
        end
        return 16'(v[3] * 4096 + v[2] * 256 + v[1] * 16 + v[0]);
    endfunction

    function automatic logic [15:0] exp_flags(int k);
        return {13'd0, (m_phase == 1), (m_match[k] != 0), (m_phase == 0)};
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("w_digits", {w_d3, w_d2, w_d1, w_d0}, exp_disp(0));
        check_val("w_code", w_code, m_code[0]);
        check_val("w_flags", {13'd0, w_cv, w_m, w_ed}, exp_flags(0));
        check_val("n_digits", {n_d3, n_d2, n_d1, n_d0}, exp_disp(1));
        check_val("n_code", n_code, m_code[1]);
        check_val("n_flags", {13'd0, n_cv, n_m, n_ed}, exp_flags(1));
    endtask

    // One clock: inputs already driven; update model at the edge, check after.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0; btn_enter = 1'b0;
    endtask

    task automatic press(input logic u, input logic d, input logic n, input logic e);
        btn_up = u; btn_down = d; btn_next = n; btn_enter = e;
        tick();
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) tick();
    endtask

    task automatic ups(input int count);
        for (int c = 0; c < count; c++) press(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    // Enter A,2,A,4 (the wildcard-off instance sees 9,2,9,4).
    task automatic enter_a2a4();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        ups(2);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        ups(4);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0; btn_enter = 1'b0;
        secret = 16'h0000;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        check_val("reset_digits", {w_d3, w_d2, w_d1, w_d0}, 16'h0000);
        check_val("reset_flags", {13'd0, w_cv, w_m, w_ed}, 16'h0001);
        rst_n = 1'b1;

        // Edit and blink of the cursor digit.
        ups(3);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        ups(1);
        check_val("tp1_digits", {w_d3, w_d2, w_d1, w_d0}, 16'h3100);
        idle(24);

        // Down-wrap from 0 and up-wrap back to 0.
        async_reset();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("wrap_down_w", {12'd0, w_d3}, 16'd10);
        check_val("wrap_down_n", {12'd0, n_d3}, 16'd9);
        ups(1);
        check_val("wrap_up", {8'd0, w_d3, n_d3}, 16'h0000);

        // Exact match: 1,2,3,4.
        async_reset();
        ups(1);
        press(1'b0, 1'b0, 1'b1, 1'b0); ups(2);
        press(1'b0, 1'b0, 1'b1, 1'b0); ups(3);
        press(1'b0, 1'b0, 1'b1, 1'b0); ups(4);
        secret = 16'h1234;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("tp3_cv", {15'd0, w_cv}, 16'd1);
        check_val("tp3_code", w_code, 16'h1234);
        secret = 16'h9999;
        tick();
        check_val("tp3_match", {15'd0, w_m}, 16'd0);
        idle(20);

        // Acknowledge: up press returns to a cleared edit session.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("tp5_digits", {w_d3, w_d2, w_d1, w_d0}, 16'h0000);
        idle(10);

        // Wildcards.
        async_reset();
        enter_a2a4();
        secret = 16'h7294;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_val("tp4_match_hit", {15'd0, w_m}, 16'd1);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        enter_a2a4();
        secret = 16'h7295;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_val("tp4_match_miss", {15'd0, w_m}, 16'd0);
        press(1'b0, 1'b0, 1'b0, 1'b1);

        // Enter beats up in the same cycle, then reset inside RESULT.
        ups(2);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("tp6_code", w_code, 16'h2000);
        tick();
        idle(3);
        async_reset();
        check_val("tp6_reset", {w_d3, w_d2, w_d1, w_d0, 13'd0, w_cv, w_m, w_ed} == 32'h0000_0001 ? 16'd1 : 16'd0, 16'd1);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 19);
            if (m_phase == 1 && $urandom_range(0, 1) == 1) begin
                logic [15:0] s;
                s = 16'd0;
                for (int i = 0; i < 4; i++) begin
                    int v;
                    v = (m_d[0][i] == 10) ? $urandom_range(0, 9) : m_d[0][i];
                    s = s | 16'(v << (4 * i));
                end
                secret = s;
            end else if ($urandom_range(0, 3) == 0) begin
                logic [15:0] s;
                s = 16'd0;
                for (int i = 0; i < 4; i++) s = s | 16'($urandom_range(0, 9) << (4 * i));
                secret = s;
            end
            if (r == 0 && $urandom_range(0, 20) == 0) begin
                async_reset();
            end else if (r < 6) begin
                tick();
            end else if (r < 10) begin
                press(1'b1, 1'b0, 1'b0, 1'b0);
            end else if (r < 13) begin
                press(1'b0, 1'b1, 1'b0, 1'b0);
            end else if (r < 15) begin
                press(1'b0, 1'b0, 1'b1, 1'b0);
            end else if (r < 17) begin
                press(1'b0, 1'b0, 1'b0, 1'b1);
            end else if (r < 18) begin
                logic [3:0] b;
                b = 4'($urandom_range(0, 15));
                press(b[0], b[1], b[2], b[3]);
            end else begin
                idle($urandom_range(5, 20));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
